// File: rtl/csa_accum.sv
// Saturating accumulator behind the 3-operand CSA stage: sums N_TERMS 5-bit
// results, then holds the total under a valid/ready output handshake.
module csa_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [4:0]       in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic             ovf, ovf_nx;
  logic             vld, vld_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [ACC_W:0]   sum_w;
  logic             accept;

  assign in_ready  = (state != DONE);
  assign accept    = in_valid && in_ready;
  assign sum_w     = (ACC_W+1)'(acc) + (ACC_W+1)'(in_sum);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_valid = vld;
  assign busy      = (state != IDLE);
  assign count     = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      vld   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      ovf   <= ovf_nx;
      vld   <= vld_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ovf_nx   = ovf;
    vld_nx   = vld;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (accept) begin
        acc_nx = ACC_W'(in_sum);
        ovf_nx = 1'b0;
        cnt_nx = 8'd1;
        if (N_TERMS == 1) begin
          state_nx = DONE;
          vld_nx   = 1'b1;
        end else begin
          state_nx = ACCUM;
        end
      end
      ACCUM: if (accept) begin
        // Carry out of the top bit pins the total at all-ones; ovf stays sticky.
        if (sum_w[ACC_W]) begin
          acc_nx = '1;
          ovf_nx = 1'b1;
        end else begin
          acc_nx = sum_w[ACC_W-1:0];
        end
        cnt_nx = cnt + 8'd1;
        if (cnt_nx == 8'(N_TERMS)) begin
          state_nx = DONE;
          vld_nx   = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        state_nx = IDLE;
        acc_nx   = '0;
        ovf_nx   = 1'b0;
        vld_nx   = 1'b0;
        cnt_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
    // Abort beats any accept or release on the same edge.
    if (clr) begin
      state_nx = IDLE;
      acc_nx   = '0;
      ovf_nx   = 1'b0;
      vld_nx   = 1'b0;
      cnt_nx   = '0;
    end
  end

endmodule

// File: doc/csa_accum.md
# csa_accum

Downstream accumulator for the 3-operand carry-save adder stage. It consumes the adder's registered 5-bit sums through a valid/ready handshake and adds `N_TERMS` of them into a saturating accumulator. It then presents the total on a held output with its own valid/ready handshake. An upstream controller asserts `in_valid` only on cycles where the adder's registered sum is meaningful.

## Interface
Parameters:
- `N_TERMS`, default 4: number of 5-bit sums per result; legal range 1..255.
- `ACC_W`, default 8: accumulator and result width; must be at least 5.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `clr`, input, 1: synchronous abort; discards the partial total and returns to IDLE.
- `in_valid`, input, 1: `in_sum` is presented.
- `in_sum`, input, 5: unsigned sum from the CSA stage, range 0..31.
- `in_ready`, output, 1: block accepts `in_sum` this cycle. Combinational from state; 1 in IDLE and ACCUM.
- `out_valid`, output, 1: registered; `out_sum` and `out_ovf` hold a finished result.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, ACC_W: registered accumulated total.
- `out_ovf`, output, 1: registered; saturation occurred in this result.
- `busy`, output, 1: state is not IDLE.
- `count`, output, 8: number of samples accepted into the current result.

## Operation
- Accept event is `in_valid && in_ready` at a rising edge.
- State IDLE:
  - `acc = 0`, `count = 0`, `out_valid = 0`, `out_ovf = 0`.
  - On accept: `acc <= in_sum`, `count <= 1`.
  - Next state is DONE if `N_TERMS == 1`, otherwise ACCUM.
- State ACCUM:
  - On accept: `acc <= sat(acc + in_sum)`, `count <= count + 1`.
  - If the new count equals `N_TERMS`, next state is DONE.
  - With no accept, all state holds.
- State DONE:
  - `out_valid = 1` and `in_ready = 0`; `in_valid` is ignored.
  - `out_sum` and `out_ovf` hold until `out_ready` is sampled high.
  - On `out_ready`, next state is IDLE. `out_valid`, `out_sum`, `out_ovf` and `count` clear on that edge.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits.
  - If bit ACC_W is set, the result saturates to `{ACC_W{1'b1}}` and `out_ovf` is set sticky until the result is consumed.
  - Once saturated, further adds keep the all-ones value.
- `out_sum` tracks the live accumulator register in ACCUM, so a partial total is visible.
- `clr`:
  - Takes effect at the next edge in any state: IDLE, `acc = 0`, `count = 0`, `out_valid = 0`, `out_ovf = 0`.
  - `clr` wins over a simultaneous accept, and that sample is dropped.
  - `clr` wins over a simultaneous `out_ready` in DONE, and the result is lost.
- `rst`:
  - Asynchronous; forces IDLE immediately.
  - Immediately forces `out_valid = 0`, `out_sum = 0`, `out_ovf = 0`, `count = 0`, `busy = 0` and `in_ready = 1`.
  - Behaviour is the same whether `rst` arrives mid-accumulation or mid-DONE.

## Timing
- Reset values: `out_valid 0`, `out_sum 0`, `out_ovf 0`, `count 0`, `busy 0`, `in_ready 1`.
- Latency: if the final sample is accepted at edge k, `out_valid` is high from edge k onward, i.e. visible in the cycle after k.
- Minimum result period is `N_TERMS + 1` cycles: N accepts plus one DONE cycle with `out_ready` already high.
- There is no accept in DONE or on the release edge. The first sample of the next result is accepted no earlier than the edge after the release.
- Gaps on `in_valid` stall accumulation without limit; there is no timeout.
- `out_ready` outside DONE has no effect.

## Test plan
- Reset mid-ACCUM: after 2 of 4 samples, pulse `rst` asynchronously between edges.
  - Required: outputs go to zero without waiting for a clock edge; `in_ready = 1`; the next 4 samples form a fresh result.
- Back-to-back, `N_TERMS = 4`, `ACC_W = 8`: `in_sum` = 5, 10, 31, 1 on consecutive cycles with `out_ready = 1`.
  - Required: `out_valid` high one cycle after the 4th accept, with `out_sum = 47`, `out_ovf = 0`, `count = 4`; back to IDLE the next cycle.
- Gapped input: the same samples with 2 idle cycles between each.
  - Required: `out_sum = 47`; `count` steps 1, 2, 3, 4 only on accept edges.
- Backpressure: result 47 in DONE, `out_ready = 0` for 3 cycles, `in_valid = 1` with `in_sum = 9` throughout.
  - Required: `in_ready = 0`; `out_sum` holds 47; the sample of 9 is not counted.
  - Then raise `out_ready`: IDLE on the next edge, and 9 is accepted as sample 1 on the edge after that.
- Saturation, `N_TERMS = 4`, `ACC_W = 6`: four samples of 31.
  - Required: `out_sum = 63`, `out_ovf = 1`.
  - The following result of 1, 1, 1, 1 gives `out_sum = 4`, `out_ovf = 0`.
- Clear collision: `clr = 1` and accept on the same edge during ACCUM with `count = 3`.
  - Required: IDLE, `count = 0`, `out_sum = 0`; the sample is dropped.
  - Also: `clr` together with `out_ready` in DONE gives `out_valid = 0` and no result is delivered.
